main_ram_arbiter: RTL and testbench

- Upstream stage of the 32-bit main RAM (15-bit word address, 4-bit byte select, 1-cycle registered read).
- Arbitrates three requestors onto the single RAM slave bus:
  - port 0: CPU byte access, read/write.
  - ports 1/2: render fetch, 32-bit word, read-only.
- Registers the bus outputs, tracks in-flight reads and routes the returned data back to the owner with a valid pulse.

---
 rtl/main_ram_arbiter_pkg.sv | 34 +++
 rtl/main_ram_arbiter_if.sv | 54 +++++
 rtl/main_ram_arb_grant.sv | 42 ++++
 rtl/main_ram_arbiter.sv | 120 ++++++++++++
 tb/tb_main_ram_arbiter.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/main_ram_arbiter_pkg.sv
// Shared constants and types for the main RAM arbiter slice.
package main_ram_pkg;

  localparam int RAM_ADDR_W = 15;
  localparam int RAM_DATA_W = 32;
  localparam int RAM_BE_W   = 4;
  localparam int CPU_ADDR_W = 17;
  localparam int STARVE_W   = 4;

  typedef enum logic [1:0] {
    PORT_CPU = 2'd0,
    PORT_R1  = 2'd1,
    PORT_R2  = 2'd2
  } port_e;

  typedef struct packed {
    logic       valid;
    port_e      port;
    logic [1:0] lane;
  } inflight_t;

  typedef struct packed {
    logic [RAM_ADDR_W-1:0] addr;
    logic [RAM_DATA_W-1:0] wrdata;
    logic [RAM_BE_W-1:0]   bytesel;
    logic                  write;
  } bus_cmd_t;

  function automatic logic [7:0] lane_byte(input logic [RAM_DATA_W-1:0] word,
                                           input logic [1:0]            lane);
    return word[{lane, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/main_ram_arbiter_if.sv
// Requestor-side handshakes plus the RAM slave bus of the main RAM arbiter.
// slave = arbiter view; master = requestors and RAM driving the arbiter.
interface main_ram_arbiter_if;
  import main_ram_pkg::*;

  logic                  cpu_req;
  logic [CPU_ADDR_W-1:0] cpu_addr;
  logic                  cpu_write;
  logic [7:0]            cpu_wrdata;
  logic                  cpu_ack;
  logic [7:0]            cpu_rddata;
  logic                  cpu_rdvalid;

  logic                  r1_req;
  logic [RAM_ADDR_W-1:0] r1_addr;
  logic                  r1_ack;
  logic [RAM_DATA_W-1:0] r1_rddata;
  logic                  r1_rdvalid;

  logic                  r2_req;
  logic [RAM_ADDR_W-1:0] r2_addr;
  logic                  r2_ack;
  logic [RAM_DATA_W-1:0] r2_rddata;
  logic                  r2_rdvalid;

  logic [RAM_ADDR_W-1:0] bus_addr;
  logic [RAM_DATA_W-1:0] bus_wrdata;
  logic [RAM_BE_W-1:0]   bus_wrbytesel;
  logic                  bus_write;
  logic [RAM_DATA_W-1:0] bus_rddata;

  modport slave (
    input  cpu_req, cpu_addr, cpu_write, cpu_wrdata,
    output cpu_ack, cpu_rddata, cpu_rdvalid,
    input  r1_req, r1_addr,
    output r1_ack, r1_rddata, r1_rdvalid,
    input  r2_req, r2_addr,
    output r2_ack, r2_rddata, r2_rdvalid,
    output bus_addr, bus_wrdata, bus_wrbytesel, bus_write,
    input  bus_rddata
  );

  modport master (
    output cpu_req, cpu_addr, cpu_write, cpu_wrdata,
    input  cpu_ack, cpu_rddata, cpu_rdvalid,
    output r1_req, r1_addr,
    input  r1_ack, r1_rddata, r1_rdvalid,
    output r2_req, r2_addr,
    input  r2_ack, r2_rddata, r2_rdvalid,
    input  bus_addr, bus_wrdata, bus_wrbytesel, bus_write,
    output bus_rddata
  );

endinterface

// File: rtl/main_ram_arb_grant.sv
// Purpose: combinational CPU-priority / render round-robin grant select with starvation cap.
// Latency: 0 cycles (pure combinational on the req inputs).
// Backpressure: none; a losing requester simply stays pending.
module main_ram_arb_grant
  import main_ram_pkg::*;
#(
  parameter int CPU_MAX_CONSEC = 4
) (
  input  logic                cpu_req,
  input  logic                r1_req,
  input  logic                r2_req,
  input  logic                rr_ptr,
  input  logic [STARVE_W-1:0] starve_cnt,
  output logic                gnt_vld,
  output port_e               gnt_port
);

  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(CPU_MAX_CONSEC);

  logic render_pend;
  logic cpu_blocked;

  assign render_pend = r1_req | r2_req;
  assign cpu_blocked = render_pend && (starve_cnt == STARVE_MAX);

  // rr_ptr = 0 prefers port 1, rr_ptr = 1 prefers port 2
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_port = PORT_CPU;
    if (cpu_req && !cpu_blocked) begin
      gnt_vld  = 1'b1;
      gnt_port = PORT_CPU;
    end else if (r1_req && (!r2_req || !rr_ptr)) begin
      gnt_vld  = 1'b1;
      gnt_port = PORT_R1;
    end else if (r2_req) begin
      gnt_vld  = 1'b1;
      gnt_port = PORT_R2;
    end
  end

endmodule

// File: rtl/main_ram_arbiter.sv
// Purpose: arbitrate CPU byte port and two render word ports onto the main RAM bus.
// Latency: ack and bus command 1 cycle after req; read data/rdvalid 2 cycles after req.
// Backpressure: req held until ack; one access per cycle, losers stay pending.
module main_ram_arbiter
  import main_ram_pkg::*;
#(
  parameter int CPU_MAX_CONSEC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  main_ram_arbiter_if.slave ram_if
);

  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(CPU_MAX_CONSEC);

  logic                gnt_vld;
  port_e               gnt_port;
  logic                render_pend;
  logic                rr_ptr;
  logic                rr_ptr_nxt;
  logic [STARVE_W-1:0] starve_cnt;
  logic [STARVE_W-1:0] starve_nxt;
  bus_cmd_t            bus_q;
  bus_cmd_t            bus_d;
  inflight_t           ifl_d;
  inflight_t           ifl_s1;
  inflight_t           ifl_s2;
  logic                cpu_ack_q;
  logic                r1_ack_q;
  logic                r2_ack_q;

  assign render_pend = ram_if.r1_req | ram_if.r2_req;

  main_ram_arb_grant #(
    .CPU_MAX_CONSEC(CPU_MAX_CONSEC)
  ) u_grant (
    .cpu_req    (ram_if.cpu_req),
    .r1_req     (ram_if.r1_req),
    .r2_req     (ram_if.r2_req),
    .rr_ptr     (rr_ptr),
    .starve_cnt (starve_cnt),
    .gnt_vld    (gnt_vld),
    .gnt_port   (gnt_port)
  );

  // Pointer moves away from the render port just served; counter only counts CPU wins over waiting render traffic.
  always_comb begin
    rr_ptr_nxt = rr_ptr;
    starve_nxt = starve_cnt;
    if (gnt_vld && gnt_port == PORT_R1) begin
      rr_ptr_nxt = 1'b1;
    end else if (gnt_vld && gnt_port == PORT_R2) begin
      rr_ptr_nxt = 1'b0;
    end
    if (!render_pend || (gnt_vld && gnt_port != PORT_CPU)) begin
      starve_nxt = '0;
    end else if (gnt_vld && starve_cnt < STARVE_MAX) begin
      starve_nxt = starve_cnt + STARVE_W'(1);
    end
  end

  always_comb begin
    bus_d         = bus_q;
    bus_d.write   = 1'b0;
    bus_d.bytesel = '0;
    ifl_d         = '0;
    if (gnt_vld) begin
      if (gnt_port == PORT_CPU) begin
        bus_d.addr    = ram_if.cpu_addr[CPU_ADDR_W-1:2];
        bus_d.wrdata  = {4{ram_if.cpu_wrdata}};
        bus_d.bytesel = RAM_BE_W'(1) << ram_if.cpu_addr[1:0];
        bus_d.write   = ram_if.cpu_write;
        ifl_d         = '{valid: !ram_if.cpu_write, port: PORT_CPU, lane: ram_if.cpu_addr[1:0]};
      end else begin
        bus_d.addr = (gnt_port == PORT_R1) ? ram_if.r1_addr : ram_if.r2_addr;
        ifl_d      = '{valid: 1'b1, port: gnt_port, lane: 2'd0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= 1'b0;
      starve_cnt <= '0;
      bus_q      <= '0;
      ifl_s1     <= '0;
      ifl_s2     <= '0;
      cpu_ack_q  <= 1'b0;
      r1_ack_q   <= 1'b0;
      r2_ack_q   <= 1'b0;
    end else begin
      rr_ptr     <= rr_ptr_nxt;
      starve_cnt <= starve_nxt;
      bus_q      <= bus_d;
      ifl_s1     <= ifl_d;
      ifl_s2     <= ifl_s1;
      cpu_ack_q  <= gnt_vld && (gnt_port == PORT_CPU);
      r1_ack_q   <= gnt_vld && (gnt_port == PORT_R1);
      r2_ack_q   <= gnt_vld && (gnt_port == PORT_R2);
    end
  end

  assign ram_if.bus_addr      = bus_q.addr;
  assign ram_if.bus_wrdata    = bus_q.wrdata;
  assign ram_if.bus_wrbytesel = bus_q.bytesel;
  assign ram_if.bus_write     = bus_q.write;

  assign ram_if.cpu_ack = cpu_ack_q;
  assign ram_if.r1_ack  = r1_ack_q;
  assign ram_if.r2_ack  = r2_ack_q;

  // ifl_s2 lines up with the cycle the RAM presents data for the access it tracks
  assign ram_if.cpu_rdvalid = ifl_s2.valid && (ifl_s2.port == PORT_CPU);
  assign ram_if.r1_rdvalid  = ifl_s2.valid && (ifl_s2.port == PORT_R1);
  assign ram_if.r2_rdvalid  = ifl_s2.valid && (ifl_s2.port == PORT_R2);
  assign ram_if.cpu_rddata  = ram_if.cpu_rdvalid ? lane_byte(ram_if.bus_rddata, ifl_s2.lane) : 8'h00;
  assign ram_if.r1_rddata   = ram_if.bus_rddata;
  assign ram_if.r2_rddata   = ram_if.bus_rddata;

endmodule

// File: tb/tb_main_ram_arbiter.sv
// Bench for main_ram_arbiter: directed vectors, write-first RAM model and a per-cycle reference model.
module tb_main_ram_arbiter;

  localparam int CPU_MAX = 4;

  logic clk;
  logic rst_n;

  main_ram_arbiter_if bus ();

  main_ram_arbiter #(.CPU_MAX_CONSEC(CPU_MAX)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ram_if (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int a);
    return 32'(a) * 32'h9E3779B1 + 32'h01234567;
  endfunction

  // Write-first RAM with a 1-cycle registered read
  logic [31:0] mem [0:32767];
  logic [31:0] ram_w;
  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = init_word(i);
    bus.bus_rddata = '0;
  end
  always @(posedge clk) begin
    ram_w = mem[bus.bus_addr];
    if (bus.bus_write) begin
      for (int b = 0; b < 4; b++)
        if (bus.bus_wrbytesel[b]) ram_w[b*8 +: 8] = bus.bus_wrdata[b*8 +: 8];
      mem[bus.bus_addr] = ram_w;
    end
    bus.bus_rddata <= ram_w;
  end

  // Reference model: expected word contents plus arbitration rules
  logic [31:0] ovr [int];
  function automatic logic [31:0] ref_rd(input int a);
    if (ovr.exists(a)) return ovr[a];
    return init_word(a);
  endfunction

  typedef struct {
    int          due;
    int          port;
    logic [31:0] data;
  } ret_t;

  ret_t        rq [$];
  int          mcyc     = 0;
  int          m_starve = 0;
  int          m_pref   = 1;
  int          e_ack    = -1;
  logic [14:0] e_addr   = '0;
  logic [31:0] e_wrdata = '0;
  logic [3:0]  e_be     = '0;
  logic        e_wr     = 1'b0;
  int          m_win;
  int          m_lane;
  int          m_a;
  logic        m_rend;
  logic [31:0] m_w;
  ret_t        m_r;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_starve = 0;
      m_pref   = 1;
      e_ack    = -1;
      e_addr   = '0;
      e_wrdata = '0;
      e_be     = '0;
      e_wr     = 1'b0;
      rq.delete();
    end else begin
      mcyc++;
      m_rend = bus.r1_req || bus.r2_req;
      if (bus.cpu_req && !(m_starve == CPU_MAX && m_rend)) m_win = 0;
      else if (bus.r1_req && bus.r2_req)                  m_win = m_pref;
      else if (bus.r1_req)                                m_win = 1;
      else if (bus.r2_req)                                m_win = 2;
      else                                                m_win = -1;
      if (m_win >= 1 || !m_rend)                   m_starve = 0;
      else if (m_win == 0 && m_starve < CPU_MAX)   m_starve++;
      if (m_win == 1) m_pref = 2;
      else if (m_win == 2) m_pref = 1;
      e_ack = m_win;
      e_wr  = 1'b0;
      e_be  = '0;
      if (m_win == 0) begin
        m_a      = int'(bus.cpu_addr[16:2]);
        m_lane   = int'(bus.cpu_addr[1:0]);
        e_addr   = bus.cpu_addr[16:2];
        e_wrdata = {4{bus.cpu_wrdata}};
        e_be     = 4'(1 << m_lane);
        e_wr     = bus.cpu_write;
        m_w      = ref_rd(m_a);
        if (bus.cpu_write) begin
          m_w[m_lane*8 +: 8] = bus.cpu_wrdata;
          ovr[m_a] = m_w;
        end else begin
          m_r.due  = mcyc + 1;
          m_r.port = 0;
          m_r.data = 32'(m_w[m_lane*8 +: 8]);
          rq.push_back(m_r);
        end
      end else if (m_win > 0) begin
        e_addr   = (m_win == 1) ? bus.r1_addr : bus.r2_addr;
        m_r.due  = mcyc + 1;
        m_r.port = m_win;
        m_r.data = ref_rd(int'(e_addr));
        rq.push_back(m_r);
      end
    end
  end

  // Per-cycle comparison against the model
  logic        cv, v1, v2;
  logic [31:0] ed;
  ret_t        c_r;
  always @(negedge clk) begin
    cv = 1'b0; v1 = 1'b0; v2 = 1'b0; ed = '0;
    if (rq.size() != 0 && rq[0].due == mcyc) begin
      c_r = rq.pop_front();
      ed  = c_r.data;
      cv  = (c_r.port == 0);
      v1  = (c_r.port == 1);
      v2  = (c_r.port == 2);
    end
    chk("cpu_ack",       32'(bus.cpu_ack),       32'(e_ack == 0));
    chk("r1_ack",        32'(bus.r1_ack),        32'(e_ack == 1));
    chk("r2_ack",        32'(bus.r2_ack),        32'(e_ack == 2));
    chk("bus_addr",      32'(bus.bus_addr),      32'(e_addr));
    chk("bus_write",     32'(bus.bus_write),     32'(e_wr));
    chk("bus_wrbytesel", 32'(bus.bus_wrbytesel), 32'(e_be));
    if (e_wr || !rst_n) chk("bus_wrdata", bus.bus_wrdata, e_wrdata);
    chk("cpu_rdvalid",   32'(bus.cpu_rdvalid),   32'(cv));
    chk("r1_rdvalid",    32'(bus.r1_rdvalid),    32'(v1));
    chk("r2_rdvalid",    32'(bus.r2_rdvalid),    32'(v2));
    if (cv) chk("cpu_rddata", 32'(bus.cpu_rddata), ed);
    if (v1) chk("r1_rddata", bus.r1_rddata, ed);
    if (v2) chk("r2_rddata", bus.r2_rddata, ed);
    if (!rst_n) chk("cpu_rddata_rst", 32'(bus.cpu_rddata), 32'h0);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_cpu(input logic q, input logic [16:0] a, input logic w, input logic [7:0] d);
    bus.cpu_req    = q;
    bus.cpu_addr   = a;
    bus.cpu_write  = w;
    bus.cpu_wrdata = d;
  endtask

  task automatic set_r(input logic q1, input logic [14:0] a1, input logic q2, input logic [14:0] a2);
    bus.r1_req  = q1;
    bus.r1_addr = a1;
    bus.r2_req  = q2;
    bus.r2_addr = a2;
  endtask

  // 0 = cpu, 1 = r1, 2 = r2, 3 = none, 4 = more than one
  function automatic int ack_code();
    int n = 0;
    int c = 3;
    if (bus.cpu_ack) begin n++; c = 0; end
    if (bus.r1_ack)  begin n++; c = 1; end
    if (bus.r2_ack)  begin n++; c = 2; end
    return (n > 1) ? 4 : c;
  endfunction

  int exp_rr [4]  = '{1, 2, 1, 2};
  int exp_st [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test sequence");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    set_cpu(1'b0, 17'h0, 1'b0, 8'h0);
    set_r(1'b0, 15'h0, 1'b0, 15'h0);
    repeat (3) tick();
    chk("rst_bus_addr",  32'(bus.bus_addr),      32'h0);
    chk("rst_bytesel",   32'(bus.bus_wrbytesel), 32'h0);
    #2 rst_n = 1'b1;

    // CPU write 0xA5 at byte 0x00006, then read it back
    tick(); set_cpu(1'b1, 17'h00006, 1'b1, 8'hA5);
    tick();
    chk("wr_bus_addr",   32'(bus.bus_addr),      32'h0001);
    chk("wr_bytesel",    32'(bus.bus_wrbytesel), 32'h4);
    chk("wr_wrdata",     bus.bus_wrdata,         32'hA5A5A5A5);
    chk("wr_write",      32'(bus.bus_write),     32'h1);
    set_cpu(1'b1, 17'h00006, 1'b0, 8'h00);
    tick();
    chk("wr_no_rdvalid", 32'(bus.cpu_rdvalid),   32'h0);
    chk("rd_cpu_ack",    32'(bus.cpu_ack),       32'h1);
    set_cpu(1'b0, 17'h0, 1'b0, 8'h0);
    tick();
    chk("rd_rdvalid",    32'(bus.cpu_rdvalid),   32'h1);
    chk("rd_rddata",     32'(bus.cpu_rddata),    32'hA5);

    // All three request together; losers hold until acked
    tick(); set_cpu(1'b1, 17'h00100, 1'b0, 8'h0); set_r(1'b1, 15'h0010, 1'b1, 15'h0020);
    tick(); chk("all3_first", 32'(ack_code()), 32'd0); set_cpu(1'b0, 17'h0, 1'b0, 8'h0);
    tick(); chk("all3_second", 32'(ack_code()), 32'd1); set_r(1'b0, 15'h0, 1'b1, 15'h0020);
    tick(); chk("all3_third", 32'(ack_code()), 32'd2); set_r(1'b0, 15'h0, 1'b0, 15'h0);
    tick(); tick();

    // Both render ports held high, CPU idle
    set_r(1'b1, 15'h0100, 1'b1, 15'h0200);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_seq", 32'(ack_code()), 32'(exp_rr[i]));
      if (i == 3) set_r(1'b0, 15'h0, 1'b0, 15'h0);
    end
    tick(); tick();

    // CPU and r1 held high: starvation cap of CPU_MAX
    set_cpu(1'b1, 17'h00203, 1'b0, 8'h0); set_r(1'b1, 15'h0300, 1'b0, 15'h0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("starve_seq", 32'(ack_code()), 32'(exp_st[i]));
      if (i == 9) begin
        set_cpu(1'b0, 17'h0, 1'b0, 8'h0);
        set_r(1'b0, 15'h0, 1'b0, 15'h0);
      end
    end
    tick(); tick();

    // CPU write at the top byte address, then read it back
    set_cpu(1'b1, 17'h1FFFF, 1'b1, 8'h3C);
    tick();
    chk("top_bus_addr", 32'(bus.bus_addr),      32'h7FFF);
    chk("top_bytesel",  32'(bus.bus_wrbytesel), 32'h8);
    set_cpu(1'b0, 17'h0, 1'b0, 8'h0);
    tick();
    chk("top_no_rdvalid", 32'(bus.cpu_rdvalid), 32'h0);
    set_cpu(1'b1, 17'h1FFFF, 1'b0, 8'h0);
    tick(); set_cpu(1'b0, 17'h0, 1'b0, 8'h0);
    tick();
    chk("top_rdvalid", 32'(bus.cpu_rdvalid), 32'h1);
    chk("top_rddata",  32'(bus.cpu_rddata),  32'h3C);

    // Reset while an r1 read is in flight
    tick(); set_r(1'b1, 15'h0400, 1'b0, 15'h0);
    tick();
    chk("mid_r1_ack", 32'(bus.r1_ack), 32'h1);
    #2 rst_n = 1'b0;
    tick();
    chk("mid_no_rdvalid", 32'(bus.r1_rdvalid), 32'h0);
    chk("mid_rst_ack",    32'(bus.r1_ack),     32'h0);
    tick();
    #2 rst_n = 1'b1;
    #1 chk("post_rst_no_ack", 32'(bus.r1_ack), 32'h0);
    tick();
    chk("post_rst_ack", 32'(bus.r1_ack), 32'h1);
    set_r(1'b0, 15'h0, 1'b0, 15'h0);
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
